// File: rtl/aha_tlx_train_pkg.sv
// -----------------------------------------------------------------------------
// aha_tlx_train_pkg
// Shared definitions for the TLX far-end training responder.
//   - PRBS7 (x^7 + x^6 + 1) width, seed and tap positions
//   - top FSM and per-lane checker state encodings
//   - helpers for the PRBS7 step: the next bit is r[6]^r[5], and the register
//     shifts left with that bit entering at r[0]
// -----------------------------------------------------------------------------
package aha_tlx_train_pkg;

    localparam int                PRBS_W     = 7;
    localparam logic [PRBS_W-1:0] PRBS_SEED  = 7'h7F;
    localparam int                PRBS_TAP_A = 6;
    localparam int                PRBS_TAP_B = 5;

    typedef enum logic [1:0] {
        TOP_OFF   = 2'd0,
        TOP_TRAIN = 2'd1,
        TOP_ACK   = 2'd2,
        TOP_DONE  = 2'd3
    } top_state_e;

    typedef enum logic [1:0] {
        CHK_FILL   = 2'd0,
        CHK_HUNT   = 2'd1,
        CHK_LOCKED = 2'd2
    } chk_state_e;

    function automatic logic prbs7_bit(input logic [PRBS_W-1:0] r);
        return r[PRBS_TAP_A] ^ r[PRBS_TAP_B];
    endfunction

    function automatic logic [PRBS_W-1:0] prbs7_shift(input logic [PRBS_W-1:0] r,
                                                      input logic              b);
        return {r[PRBS_W-2:0], b};
    endfunction

endpackage

// File: rtl/aha_tlx_train_responder_if.sv
// -----------------------------------------------------------------------------
// aha_tlx_train_responder_if
// Bundles the training-side signals of the TLX far-end responder.
//   master : link-side logic (drives TRAIN_EN, CLR_ERR, LANE_IN, TX_LANE_IN)
//   slave  : the responder (drives TX_LANE_OUT, LANE_LOCKED, ALL_LOCKED,
//            TRAIN_DONE, ERR_CNT)
// ERR_CNT packs one ERR_W counter per lane, lane 0 in the LSBs.
// -----------------------------------------------------------------------------
interface aha_tlx_train_responder_if #(
    parameter int NUM_LANES = 3,
    parameter int NUM_TX    = 2,
    parameter int ERR_W     = 16
);
    logic                       TRAIN_EN;
    logic                       CLR_ERR;
    logic [NUM_LANES-1:0]       LANE_IN;
    logic [NUM_TX-1:0]          TX_LANE_IN;
    logic [NUM_TX-1:0]          TX_LANE_OUT;
    logic [NUM_LANES-1:0]       LANE_LOCKED;
    logic                       ALL_LOCKED;
    logic                       TRAIN_DONE;
    logic [NUM_LANES*ERR_W-1:0] ERR_CNT;

    modport master (
        output TRAIN_EN, CLR_ERR, LANE_IN, TX_LANE_IN,
        input  TX_LANE_OUT, LANE_LOCKED, ALL_LOCKED, TRAIN_DONE, ERR_CNT
    );

    modport slave (
        input  TRAIN_EN, CLR_ERR, LANE_IN, TX_LANE_IN,
        output TX_LANE_OUT, LANE_LOCKED, ALL_LOCKED, TRAIN_DONE, ERR_CNT
    );
endinterface

// File: rtl/aha_tlx_prbs7_checker.sv
// -----------------------------------------------------------------------------
// aha_tlx_prbs7_checker
// Single-lane PRBS7 checker, FILL -> HUNT -> LOCKED.
//   clk, rst_n  : link clock, async active-low reset
//   en_i        : training enable; low forces FILL and clears match/miss counts
//   clr_err_i   : synchronous error-counter clear (wins over an increment)
//   lane_i      : received lane bit
//   locked_o    : registered, high exactly while in LOCKED
//   err_cnt_o   : saturating mismatch count while LOCKED
// Optional: AHA_TLX_TRAIN_ERRCNT_EN builds the error counter; without it
// err_cnt_o is tied to zero and clr_err_i is ignored.
// -----------------------------------------------------------------------------
module aha_tlx_prbs7_checker
    import aha_tlx_train_pkg::*;
#(
    parameter int LOCK_CNT = 64,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_err_i,
    input  logic             lane_i,
    output logic             locked_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam int FW = $clog2(PRBS_W);

    chk_state_e        state_q, state_d;
    logic [PRBS_W-1:0] r_q, r_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [MW-1:0]     match_q, match_d;
    logic [LW-1:0]     miss_q, miss_d;
    logic              locked_q;
    logic              pred;
    logic              hit;
    logic              lock_err;

    assign pred = prbs7_bit(r_q);
    // An all-zero register is the LFSR lockup state and never a valid PRBS7
    // phase; without this a stuck-at-0 lane would predict 0 forever and lock.
    assign hit      = (lane_i == pred) && (r_q != '0);
    assign lock_err = en_i && (state_q == CHK_LOCKED) && (lane_i != pred);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (!en_i) begin
            state_d = CHK_FILL;
            fill_d  = '0;
            match_d = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                CHK_FILL: begin
                    r_d = prbs7_shift(r_q, lane_i);
                    if (fill_q == FW'(PRBS_W - 1)) begin
                        state_d = CHK_HUNT;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FW'(1);
                    end
                end
                CHK_HUNT: begin
                    // Self-synchronising: the received bit always enters r.
                    r_d = prbs7_shift(r_q, lane_i);
                    if (hit) begin
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_d = CHK_LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                CHK_LOCKED: begin
                    // Free-running: errors on the wire do not corrupt r.
                    r_d = prbs7_shift(r_q, pred);
                    if (lane_i != pred) begin
                        if (miss_q == LW'(LOSS_CNT - 1)) begin
                            state_d = CHK_FILL;
                            fill_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + LW'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = CHK_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CHK_HUNT;
            r_q      <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= (state_d == CHK_LOCKED);
        end
    end

    assign locked_o = locked_q;

`ifdef AHA_TLX_TRAIN_ERRCNT_EN
    logic [ERR_W-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (clr_err_i) begin
            err_d = '0;
        end else if (lock_err && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt_o = err_q;
`else
    logic unused_err;
    assign unused_err = clr_err_i ^ lock_err;
    assign err_cnt_o  = '0;
`endif

endmodule

// File: rtl/aha_tlx_train_responder.sv
// -----------------------------------------------------------------------------
// aha_tlx_train_responder
// Far-end TLX lane-training responder on the FWD receive side.
//   TLX_FWD_CLK    : link clock, sole clock of the block
//   TLX_FWD_RESETn : async active-low reset
//   bus (slave)    : TRAIN_EN, CLR_ERR, LANE_IN, TX_LANE_IN in;
//                    TX_LANE_OUT, LANE_LOCKED, ALL_LOCKED, TRAIN_DONE, ERR_CNT out
// One PRBS7 checker per received lane; a PRBS7 generator drives every return
// lane while training, otherwise TX_LANE_IN is passed through (1 cycle).
// Top FSM OFF -> TRAIN -> ACK -> DONE; TRAIN_EN low returns to OFF.
// Optional: AHA_TLX_TRAIN_ERRCNT_EN enables the per-lane error counters.
// -----------------------------------------------------------------------------
module aha_tlx_train_responder
    import aha_tlx_train_pkg::*;
#(
    parameter int NUM_LANES  = 3,
    parameter int NUM_TX     = 2,
    parameter int LOCK_CNT   = 64,
    parameter int LOSS_CNT   = 4,
    parameter int ACK_CYCLES = 256,
    parameter int ERR_W      = 16
) (
    input  logic                    TLX_FWD_CLK,
    input  logic                    TLX_FWD_RESETn,
    aha_tlx_train_responder_if.slave bus
);

    localparam int AW = $clog2(ACK_CYCLES + 1);

    top_state_e                            state_q, state_d;
    logic [PRBS_W-1:0]                     gen_q, gen_d;
    logic [NUM_TX-1:0]                     tx_q, tx_d;
    logic [AW-1:0]                         ack_q, ack_d;
    logic [NUM_LANES-1:0]                  locked;
    logic [NUM_LANES-1:0][ERR_W-1:0]       err_cnt;
    logic                                  all_locked;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        aha_tlx_prbs7_checker #(
            .LOCK_CNT (LOCK_CNT),
            .LOSS_CNT (LOSS_CNT),
            .ERR_W    (ERR_W)
        ) u_chk (
            .clk       (TLX_FWD_CLK),
            .rst_n     (TLX_FWD_RESETn),
            .en_i      (bus.TRAIN_EN),
            .clr_err_i (bus.CLR_ERR),
            .lane_i    (bus.LANE_IN[g]),
            .locked_o  (locked[g]),
            .err_cnt_o (err_cnt[g])
        );
    end

    assign all_locked = &locked;

    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        ack_d   = ack_q;
        // Output mux follows the current state, so pass-through resumes the
        // cycle after the FSM has actually landed in OFF.
        tx_d    = (state_q == TOP_OFF) ? bus.TX_LANE_IN : {NUM_TX{prbs7_bit(gen_q)}};
        if (state_q != TOP_OFF) begin
            gen_d = prbs7_shift(gen_q, prbs7_bit(gen_q));
        end
        if (!bus.TRAIN_EN) begin
            state_d = TOP_OFF;
            gen_d   = PRBS_SEED;
            ack_d   = '0;
        end else begin
            case (state_q)
                TOP_OFF:   state_d = TOP_TRAIN;
                TOP_TRAIN: begin
                    if (all_locked) begin
                        state_d = TOP_ACK;
                        ack_d   = '0;
                    end
                end
                TOP_ACK: begin
                    if (!all_locked) begin
                        state_d = TOP_TRAIN;
                    end else if (ack_q == AW'(ACK_CYCLES - 1)) begin
                        state_d = TOP_DONE;
                    end else begin
                        ack_d = ack_q + AW'(1);
                    end
                end
                TOP_DONE: begin
                    if (!all_locked) begin
                        state_d = TOP_TRAIN;
                    end
                end
                default: state_d = TOP_OFF;
            endcase
        end
    end

    always_ff @(posedge TLX_FWD_CLK or negedge TLX_FWD_RESETn) begin
        if (!TLX_FWD_RESETn) begin
            state_q <= TOP_OFF;
            gen_q   <= PRBS_SEED;
            tx_q    <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            tx_q    <= tx_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.TX_LANE_OUT = tx_q;
    assign bus.LANE_LOCKED = locked;
    assign bus.ALL_LOCKED  = all_locked;
    assign bus.TRAIN_DONE  = (state_q == TOP_DONE);
    assign bus.ERR_CNT     = err_cnt;

endmodule

// File: tb/tb_aha_tlx_train_responder.sv
// -----------------------------------------------------------------------------
// tb_aha_tlx_train_responder
// Directed bench: a pass-through vector table, then hand-written sequences
// for lock timing, error injection, loss of lock, stuck lane, counter
// saturation/clear, TRAIN_EN drop and mid-operation reset.  ERR_W is 8 here
// so saturation is reachable in a few hundred cycles.
// -----------------------------------------------------------------------------
module tb_aha_tlx_train_responder;

    localparam int NL = 3;
    localparam int NT = 2;
    localparam int EW = 8;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    aha_tlx_train_responder_if #(.NUM_LANES(NL), .NUM_TX(NT), .ERR_W(EW)) bus ();

    aha_tlx_train_responder #(
        .NUM_LANES  (NL),
        .NUM_TX     (NT),
        .LOCK_CNT   (64),
        .LOSS_CNT   (4),
        .ACK_CYCLES (256),
        .ERR_W      (EW)
    ) dut (
        .TLX_FWD_CLK    (clk),
        .TLX_FWD_RESETn (rst_n),
        .bus            (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] lm [NL];
    logic [6:0] txm;

    typedef struct {
        logic          train_en;
        logic [NT-1:0] tx_in;
        logic [NT-1:0] exp_tx;
        logic [NL-1:0] exp_locked;
        logic          exp_done;
    } vec_t;

    vec_t vt [4];

    function automatic logic pbit(input logic [6:0] r);
        return r[6] ^ r[5];
    endfunction

    function automatic logic [6:0] pnext(input logic [6:0] r);
        return {r[5:0], r[6] ^ r[5]};
    endfunction

    // Expected counter value: counters only exist with the feature macro.
    function automatic logic [EW-1:0] ecnt(input int v);
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
        return EW'(v);
`else
        return EW'(v) & {EW{1'b0}};
`endif
    endfunction

    function automatic logic [EW-1:0] err_of(input int lane);
        return bus.ERR_CNT[lane*EW +: EW];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one bit per lane from the lane models, with optional flips and
    // stuck-at-0, then advance one clock.
    task automatic lanes(input logic [NL-1:0] flip, input logic [NL-1:0] stuck0);
        logic [NL-1:0] v;
        for (int i = 0; i < NL; i++) begin
            v[i]  = (pbit(lm[i]) ^ flip[i]) & ~stuck0[i];
            lm[i] = pnext(lm[i]);
        end
        bus.LANE_IN = v;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vt[0] = '{1'b0, 2'b10, 2'b10, 3'b000, 1'b0};
        vt[1] = '{1'b0, 2'b01, 2'b01, 3'b000, 1'b0};
        vt[2] = '{1'b0, 2'b11, 2'b11, 3'b000, 1'b0};
        vt[3] = '{1'b0, 2'b00, 2'b00, 3'b000, 1'b0};

        // ---------------- reset ----------------
        rst_n          = 1'b0;
        bus.TRAIN_EN   = 1'b0;
        bus.CLR_ERR    = 1'b0;
        bus.LANE_IN    = '0;
        bus.TX_LANE_IN = 2'b11;
        #3;
        chk("rst_tx",     32'(bus.TX_LANE_OUT), 32'(2'b00));
        chk("rst_locked", 32'(bus.LANE_LOCKED), 32'(3'b000));
        chk("rst_all",    32'(bus.ALL_LOCKED),  32'(1'b0));
        chk("rst_done",   32'(bus.TRAIN_DONE),  32'(1'b0));
        chk("rst_err",    32'(bus.ERR_CNT),     32'(0));
        tick();
        tick();
        chk("rst_tx_held", 32'(bus.TX_LANE_OUT), 32'(2'b00));
        rst_n = 1'b1;

        // ---------------- pass-through table ----------------
        for (int v = 0; v < 4; v++) begin
            bus.TRAIN_EN   = vt[v].train_en;
            bus.TX_LANE_IN = vt[v].tx_in;
            tick();
            chk("tbl_tx",     32'(bus.TX_LANE_OUT), 32'(vt[v].exp_tx));
            chk("tbl_locked", 32'(bus.LANE_LOCKED), 32'(vt[v].exp_locked));
            chk("tbl_done",   32'(bus.TRAIN_DONE),  32'(vt[v].exp_done));
        end

        // ---------------- clean training ----------------
        bus.TRAIN_EN   = 1'b1;
        bus.TX_LANE_IN = 2'b01;
        for (int i = 0; i < NL; i++) lm[i] = 7'h7F;
        txm = 7'h7F;
        for (int k = 0; k <= 330; k++) begin
            lanes(3'b000, 3'b000);
            if (k == 0) begin
                chk("tx_first_edge_pass", 32'(bus.TX_LANE_OUT), 32'(2'b01));
            end else if (k <= 16) begin
                chk("tx_prbs", 32'(bus.TX_LANE_OUT), 32'({NT{pbit(txm)}}));
                txm = pnext(txm);
            end
            if (k == 69) chk("locked_before_71", 32'(bus.LANE_LOCKED), 32'(3'b000));
            if (k == 70) begin
                chk("locked_at_71", 32'(bus.LANE_LOCKED), 32'(3'b111));
                chk("all_locked",   32'(bus.ALL_LOCKED),  32'(1'b1));
            end
            if (k == 326) chk("done_before_ack", 32'(bus.TRAIN_DONE), 32'(1'b0));
            if (k == 327) chk("done_after_ack",  32'(bus.TRAIN_DONE), 32'(1'b1));
        end
        chk("clean_err", 32'(bus.ERR_CNT), 32'(0));

        // ---------------- isolated flips on lane 1 ----------------
        for (int j = 0; j < 30; j++) begin
            lanes((j % 10 == 0) ? 3'b010 : 3'b000, 3'b000);
        end
        chk("iso_err1",    32'(err_of(1)), 32'(ecnt(3)));
        chk("iso_locked",  32'(bus.LANE_LOCKED), 32'(3'b111));
        chk("iso_done",    32'(bus.TRAIN_DONE),  32'(1'b1));

        // ---------------- four consecutive flips: loss ----------------
        lanes(3'b010, 3'b000);
        lanes(3'b010, 3'b000);
        lanes(3'b010, 3'b000);
        chk("three_miss_locked", 32'(bus.LANE_LOCKED), 32'(3'b111));
        lanes(3'b010, 3'b000);
        chk("loss_locked", 32'(bus.LANE_LOCKED), 32'(3'b101));
        chk("loss_all",    32'(bus.ALL_LOCKED),  32'(1'b0));
        chk("loss_err1",   32'(err_of(1)),       32'(ecnt(7)));
        lanes(3'b000, 3'b000);
        chk("loss_done_drop", 32'(bus.TRAIN_DONE), 32'(1'b0));

        n = 0;
        while (!bus.TRAIN_DONE && n < 600) begin
            lanes(3'b000, 3'b000);
            n++;
        end
        chk("relock_done", 32'(bus.TRAIN_DONE), 32'(1'b1));

        // ---------------- TRAIN_EN drop in DONE ----------------
        bus.TRAIN_EN   = 1'b0;
        bus.TX_LANE_IN = 2'b10;
        lanes(3'b000, 3'b000);
        chk("drop_done",   32'(bus.TRAIN_DONE),  32'(1'b0));
        chk("drop_locked", 32'(bus.LANE_LOCKED), 32'(3'b000));
        lanes(3'b000, 3'b000);
        chk("drop_pass",   32'(bus.TX_LANE_OUT), 32'(2'b10));
        chk("drop_err_held", 32'(err_of(1)),     32'(ecnt(7)));

        // ---------------- re-enable, lane 2 stuck at 0 ----------------
        bus.TRAIN_EN = 1'b1;
        txm = 7'h7F;
        for (int k = 0; k < 200; k++) begin
            lanes(3'b000, 3'b100);
            if (k == 0) begin
                chk("reen_pass", 32'(bus.TX_LANE_OUT), 32'(2'b10));
            end else if (k <= 10) begin
                chk("reen_tx_prbs", 32'(bus.TX_LANE_OUT), 32'({NT{pbit(txm)}}));
                txm = pnext(txm);
            end
        end
        chk("stuck_locked", 32'(bus.LANE_LOCKED), 32'(3'b011));
        chk("stuck_done",   32'(bus.TRAIN_DONE),  32'(1'b0));

        n = 0;
        while (!bus.LANE_LOCKED[2] && n < 71) begin
            lanes(3'b000, 3'b000);
            n++;
        end
        chk("release_lock71", 32'(bus.LANE_LOCKED), 32'(3'b111));
        n = 0;
        while (!bus.TRAIN_DONE && n < 400) begin
            lanes(3'b000, 3'b000);
            n++;
        end
        chk("release_done", 32'(bus.TRAIN_DONE), 32'(1'b1));

        // ---------------- CLR_ERR and saturation on lane 2 ----------------
        bus.CLR_ERR = 1'b1;
        lanes(3'b000, 3'b000);
        bus.CLR_ERR = 1'b0;
        chk("clr_all", 32'(bus.ERR_CNT), 32'(0));

        for (int g = 0; g < 86; g++) begin
            lanes(3'b100, 3'b000);
            lanes(3'b100, 3'b000);
            lanes(3'b100, 3'b000);
            lanes(3'b000, 3'b000);
            if (g == 1) chk("err_count6", 32'(err_of(2)), 32'(ecnt(6)));
        end
        chk("sat_err2",   32'(err_of(2)),       32'(ecnt(255)));
        chk("sat_locked", 32'(bus.LANE_LOCKED), 32'(3'b111));
        chk("sat_err0",   32'(err_of(0)),       32'(0));
        lanes(3'b100, 3'b000);
        lanes(3'b000, 3'b000);
        chk("sat_hold", 32'(err_of(2)), 32'(ecnt(255)));

        bus.CLR_ERR = 1'b1;
        lanes(3'b100, 3'b000);
        bus.CLR_ERR = 1'b0;
        chk("clr_priority", 32'(err_of(2)), 32'(0));
        lanes(3'b000, 3'b000);
        lanes(3'b100, 3'b000);
        chk("count_after_clr", 32'(err_of(2)), 32'(ecnt(1)));

        // ---------------- mid-operation reset ----------------
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx",     32'(bus.TX_LANE_OUT), 32'(2'b00));
        chk("mid_rst_locked", 32'(bus.LANE_LOCKED), 32'(3'b000));
        chk("mid_rst_done",   32'(bus.TRAIN_DONE),  32'(1'b0));
        chk("mid_rst_err",    32'(bus.ERR_CNT),     32'(0));
        bus.TRAIN_EN   = 1'b0;
        bus.TX_LANE_IN = 2'b11;
        tick();
        chk("mid_rst_tx_held", 32'(bus.TX_LANE_OUT), 32'(2'b00));
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_pass", 32'(bus.TX_LANE_OUT), 32'(2'b11));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
